// File: rtl/ms_input_pkg.sv
// ms_input_pkg
// Shared constants, click FSM encoding and a board-bounds helper for the
// minesweeper input conditioner.
// Ports: none (package).

package ms_input_pkg;

    localparam int BOARD_DIM = 8;
    localparam int CURSOR_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_L_HELD   = 3'd1,
        ST_R_HELD   = 3'd2,
        ST_CHORD    = 3'd3,
        ST_WAIT_REL = 3'd4
    } click_state_e;

    // d is an 11-bit two's complement pixel offset from the board edge.
    // Inside means non-negative and fewer than BOARD_DIM whole tiles away.
    function automatic logic in_board(input logic [10:0] d, input int unsigned sh);
        return (d[10] == 1'b0) && ((d >> sh) < 11'(BOARD_DIM));
    endfunction

endpackage

// File: rtl/ms_input_if.sv
// ms_input_if
// Bundles the raw mouse/key inputs and the conditioned click/cursor outputs.
//   btn_left/btn_right/btn_retry : raw button levels, 1 = pressed
//   mouse_x/mouse_y/xy_valid     : pointer pixel position and its strobe
//   left/right/retry             : one-cycle pulses to the core
//   cursor/game_area             : tile index {row,col} and in-board flag
// master = upstream/core side, slave = the conditioner.

interface ms_input_if;
    import ms_input_pkg::*;

    logic                btn_left;
    logic                btn_right;
    logic                btn_retry;
    logic [9:0]          mouse_x;
    logic [9:0]          mouse_y;
    logic                xy_valid;
    logic                left;
    logic                right;
    logic                retry;
    logic [CURSOR_W-1:0] cursor;
    logic                game_area;

    modport master (
        output btn_left, btn_right, btn_retry, mouse_x, mouse_y, xy_valid,
        input  left, right, retry, cursor, game_area
    );

    modport slave (
        input  btn_left, btn_right, btn_retry, mouse_x, mouse_y, xy_valid,
        output left, right, retry, cursor, game_area
    );

endinterface

// File: rtl/ms_input_debounce.sv
// ms_debounce
// Two-flop synchroniser followed by a stability counter. The output level
// toggles only after the synchronised input has disagreed with it for
// DEB_CYCLES consecutive cycles.
//   clk     : system clock
//   reset   : asynchronous active-high reset
//   raw_i   : raw asynchronous level
//   level_o : debounced level

module ms_debounce #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);

    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        level_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_CYCLES - 16'd1) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/ms_input.sv
// ms_input
// Conditions raw mouse buttons and pointer coordinates for the minesweeper
// core: debounced click pulses (chord = left and right in the same cycle),
// a debounced retry pulse, and the tile under the pointer.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : ms_input_if.slave (raw inputs in, conditioned outputs out)
//
// Click FSM
//   state    | meaning
//   IDLE     | no button owned by a click
//   L_HELD   | left down alone; reveal fires on its release
//   R_HELD   | right down alone; flag already fired on press
//   CHORD    | both down; first release fires left+right together
//   WAIT_REL | chord done; ignore everything until both buttons are up

module ms_input
    import ms_input_pkg::*;
#(
    parameter logic [9:0]  BOARD_X0   = 10'd192,
    parameter logic [9:0]  BOARD_Y0   = 10'd112,
    parameter int unsigned TILE_LOG2  = 5,
    parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    ms_input_if.slave  bus
);

    logic       deb_l;
    logic       deb_r;
    logic       deb_t;
    logic [2:0] lvl;

    ms_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
        .clk(clk), .reset(reset), .raw_i(bus.btn_left), .level_o(deb_l)
    );
    ms_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
        .clk(clk), .reset(reset), .raw_i(bus.btn_right), .level_o(deb_r)
    );
    ms_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_retry (
        .clk(clk), .reset(reset), .raw_i(bus.btn_retry), .level_o(deb_t)
    );

    assign lvl = {deb_t, deb_r, deb_l};

    // Bit 0 = left, 1 = right, 2 = retry. Retry only needs its rising edge.
    logic [2:0] prev_q;
    logic [2:0] rise_q;
    logic [1:0] fall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            prev_q <= lvl;
            rise_q <= lvl & ~prev_q;
            fall_q <= ~lvl[1:0] & prev_q[1:0];
        end
    end

    // Pointer position relative to the board, as 11-bit signed offsets.
    logic [10:0]         dx_w;
    logic [10:0]         dy_w;
    logic [CURSOR_W-1:0] cursor_q;
    logic [CURSOR_W-1:0] cursor_d;
    logic                game_area_q;
    logic                game_area_d;

    assign dx_w = {1'b0, bus.mouse_x} - {1'b0, BOARD_X0};
    assign dy_w = {1'b0, bus.mouse_y} - {1'b0, BOARD_Y0};

    always_comb begin
        cursor_d    = cursor_q;
        game_area_d = game_area_q;
        if (bus.xy_valid) begin
            // Outside the board these bits are meaningless; game_area marks that.
            cursor_d    = {dy_w[TILE_LOG2+2:TILE_LOG2], dx_w[TILE_LOG2+2:TILE_LOG2]};
            game_area_d = in_board(dx_w, TILE_LOG2) && in_board(dy_w, TILE_LOG2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cursor_q    <= '0;
            game_area_q <= 1'b0;
        end else begin
            cursor_q    <= cursor_d;
            game_area_q <= game_area_d;
        end
    end

    // Click FSM
    click_state_e state_q;
    click_state_e state_d;
    logic         left_c;
    logic         right_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A release seen in the same cycle as the other button's press wins:
    // the click completes rather than turning into a chord.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_q[0] && rise_q[1]) state_d = ST_CHORD;
                else if (rise_q[0])         state_d = ST_L_HELD;
                else if (rise_q[1])         state_d = ST_R_HELD;
            end
            ST_L_HELD: begin
                if (fall_q[0])      state_d = ST_IDLE;
                else if (rise_q[1]) state_d = ST_CHORD;
            end
            ST_R_HELD: begin
                if (fall_q[1])      state_d = ST_IDLE;
                else if (rise_q[0]) state_d = ST_CHORD;
            end
            ST_CHORD: begin
                if (fall_q[0] || fall_q[1]) state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!deb_l && !deb_r) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        left_c  = 1'b0;
        right_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                right_c = rise_q[1] && !rise_q[0];
            end
            ST_L_HELD: begin
                left_c = fall_q[0];
            end
            ST_CHORD: begin
                left_c  = fall_q[0] || fall_q[1];
                right_c = fall_q[0] || fall_q[1];
            end
            default: begin
                left_c  = 1'b0;
                right_c = 1'b0;
            end
        endcase
    end

    assign bus.left      = left_c;
    assign bus.right     = right_c;
    assign bus.retry     = rise_q[2];
    assign bus.cursor    = cursor_q;
    assign bus.game_area = game_area_q;

endmodule

// File: tb/tb_ms_input.sv
// tb_ms_input
// Bench for ms_input with a short debounce window. A behavioural model
// tracks the expected pulses, cursor and game_area every cycle; directed
// scenarios add latency and pulse-count checks.

module tb_ms_input;

    localparam int D = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    ms_input_if bus();

    ms_input #(
        .BOARD_X0(10'd192),
        .BOARD_Y0(10'd112),
        .TILE_LOG2(5),
        .DEB_CYCLES(16'd4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: raw sample history per button (index 0 = newest edge),
    // debounced levels, pending edge events, click bookkeeping, coordinates.
    int h [3][16];
    int deb [3];
    int ev_rise [3];
    int ev_fall [3];
    bit hold_l, hold_r, chord, drain;
    int m_cur, m_ga;
    int cnt_l, cnt_r, cnt_t, cnt_lr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) h[b][i] = 0;
            deb[b] = 0;
            ev_rise[b] = 0;
            ev_fall[b] = 0;
        end
        hold_l = 0; hold_r = 0; chord = 0; drain = 0;
        m_cur = 0; m_ga = 0;
    endtask

    function automatic int raw_of(input int b);
        if (b == 0) return int'(bus.btn_left);
        if (b == 1) return int'(bus.btn_right);
        return int'(bus.btn_retry);
    endfunction

    // Called 1 ns after each rising edge.
    task automatic model_step();
        int xl, xr, dx, dy;
        int nr [3];
        int nf [3];
        bit all_diff;
        xl = 0; xr = 0;
        if (drain) begin
            xl = 0;
        end else if (chord) begin
            if (ev_fall[0] != 0 || ev_fall[1] != 0) begin xl = 1; xr = 1; end
        end else if (hold_l) begin
            if (ev_fall[0] != 0) xl = 1;
        end else if (!hold_r) begin
            if (ev_rise[1] != 0 && ev_rise[0] == 0) xr = 1;
        end
        if (bus.xy_valid) begin
            dx = int'(bus.mouse_x) - 192;
            dy = int'(bus.mouse_y) - 112;
            m_ga  = (dx >= 0 && dx < 256 && dy >= 0 && dy < 256) ? 1 : 0;
            m_cur = (((((dy + 2048) % 2048) / 32) % 8) * 8) + ((((dx + 2048) % 2048) / 32) % 8);
        end
        chk("left",      32'(bus.left),      32'(xl));
        chk("right",     32'(bus.right),     32'(xr));
        chk("retry",     32'(bus.retry),     32'(ev_rise[2]));
        chk("cursor",    32'(bus.cursor),    32'(m_cur));
        chk("game_area", 32'(bus.game_area), 32'(m_ga));
        cnt_l  += int'(bus.left);
        cnt_r  += int'(bus.right);
        cnt_t  += int'(bus.retry);
        cnt_lr += int'(bus.left & bus.right);

        // A level flips once the last D synchronised samples (two edges old
        // and earlier) all disagree with it.
        for (int b = 0; b < 3; b++) begin
            for (int i = 15; i > 0; i--) h[b][i] = h[b][i-1];
            h[b][0] = raw_of(b);
            all_diff = 1;
            for (int i = 2; i < 2 + D; i++) if (h[b][i] == deb[b]) all_diff = 0;
            nr[b] = 0; nf[b] = 0;
            if (all_diff) begin
                if (deb[b] == 0) nr[b] = 1; else nf[b] = 1;
                deb[b] = 1 - deb[b];
            end
        end

        if (drain) begin
            if (deb[0] == 0 && deb[1] == 0) drain = 0;
        end else if (chord) begin
            if (ev_fall[0] != 0 || ev_fall[1] != 0) begin chord = 0; drain = 1; end
        end else if (hold_l) begin
            if (ev_fall[0] != 0) hold_l = 0;
            else if (ev_rise[1] != 0) begin hold_l = 0; chord = 1; end
        end else if (hold_r) begin
            if (ev_fall[1] != 0) hold_r = 0;
            else if (ev_rise[0] != 0) begin hold_r = 0; chord = 1; end
        end else begin
            if (ev_rise[0] != 0 && ev_rise[1] != 0) chord = 1;
            else if (ev_rise[0] != 0) hold_l = 1;
            else if (ev_rise[1] != 0) hold_r = 1;
        end

        for (int b = 0; b < 3; b++) begin
            ev_rise[b] = nr[b];
            ev_fall[b] = nf[b];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_counts();
        cnt_l = 0; cnt_r = 0; cnt_t = 0; cnt_lr = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_left"},   32'(bus.left),      32'd0);
        chk({tag, "_right"},  32'(bus.right),     32'd0);
        chk({tag, "_retry"},  32'(bus.retry),     32'd0);
        chk({tag, "_cursor"}, 32'(bus.cursor),    32'd0);
        chk({tag, "_ga"},     32'(bus.game_area), 32'd0);
    endtask

    // Asserts reset away from the clock edge, checks outputs drop, holds two edges.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check_outputs_zero(tag);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Number of edges until the selected pulse shows, capped at 40.
    task automatic wait_pulse(input int which, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n++;
            if ((which == 0 && bus.left) || (which == 1 && bus.right)) break;
        end
    endtask

    int lat;

    initial begin
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_retry = 1'b0;
        bus.mouse_x   = 10'd0;
        bus.mouse_y   = 10'd0;
        bus.xy_valid  = 1'b0;
        clear_counts();
        #2;

        // Left held through reset release: nothing on press, one pulse on release.
        bus.btn_left = 1'b1;
        do_reset("rst0");
        clear_counts();
        run(12);
        chk("held_no_pulse", 32'(cnt_l), 32'd0);
        bus.btn_left = 1'b0;
        wait_pulse(0, lat);
        chk("rel_latency", 32'(lat), 32'(D + 3));
        run(3);
        chk("held_rel_cnt", 32'(cnt_l), 32'd1);

        // Bounce 1-0-1 then a steady hold.
        run(10);
        clear_counts();
        bus.btn_left = 1'b1; cycle();
        bus.btn_left = 1'b0; cycle();
        bus.btn_left = 1'b1; run(11);
        bus.btn_left = 1'b0; run(12);
        chk("bounce_left_cnt",  32'(cnt_l), 32'd1);
        chk("bounce_right_cnt", 32'(cnt_r), 32'd0);

        // Right: flag on press, silent release.
        clear_counts();
        bus.btn_right = 1'b1;
        wait_pulse(1, lat);
        chk("right_press_lat", 32'(lat), 32'(D + 3));
        run(20);
        bus.btn_right = 1'b0;
        run(12);
        chk("right_cnt", 32'(cnt_r), 32'd1);
        chk("right_left_cnt", 32'(cnt_l), 32'd0);

        // Chord: left, right 5 later, right release fires both, left release silent.
        clear_counts();
        bus.btn_left = 1'b1;  run(5);
        bus.btn_right = 1'b1; run(12);
        bus.btn_right = 1'b0; run(12);
        chk("chord_lr_cnt", 32'(cnt_lr), 32'd1);
        chk("chord_l_cnt",  32'(cnt_l),  32'd1);
        chk("chord_r_cnt",  32'(cnt_r),  32'd1);
        bus.btn_left = 1'b0;  run(12);
        chk("chord_tail_l", 32'(cnt_l), 32'd1);
        bus.btn_left = 1'b1;  run(10);
        bus.btn_left = 1'b0;  run(12);
        chk("post_chord_click", 32'(cnt_l), 32'd2);

        // Retry pulse.
        clear_counts();
        bus.btn_retry = 1'b1; run(12);
        bus.btn_retry = 1'b0; run(12);
        chk("retry_cnt", 32'(cnt_t), 32'd1);

        // Coordinates.
        bus.mouse_x = 10'(192 + 3*32 + 5);
        bus.mouse_y = 10'(112 + 6*32);
        bus.xy_valid = 1'b1; cycle(); bus.xy_valid = 1'b0;
        chk("coord_cursor", 32'(bus.cursor), 32'h33);
        chk("coord_ga_in",  32'(bus.game_area), 32'd1);
        run(3);
        chk("coord_hold", 32'(bus.cursor), 32'h33);
        bus.mouse_x = 10'd191;
        bus.xy_valid = 1'b1; cycle(); bus.xy_valid = 1'b0;
        chk("coord_x_left_out", 32'(bus.game_area), 32'd0);
        bus.mouse_x = 10'd200;
        bus.mouse_y = 10'(112 + 256);
        bus.xy_valid = 1'b1; cycle(); bus.xy_valid = 1'b0;
        chk("coord_y_below_out", 32'(bus.game_area), 32'd0);
        bus.mouse_y = 10'(112 + 255);
        bus.mouse_x = 10'(192 + 255);
        bus.xy_valid = 1'b1; cycle(); bus.xy_valid = 1'b0;
        chk("coord_corner_in", 32'(bus.game_area), 32'd1);
        chk("coord_corner_cur", 32'(bus.cursor), 32'h3f);

        // Async reset while the chord pulse is high.
        run(4);
        bus.btn_left = 1'b1;  run(5);
        bus.btn_right = 1'b1; run(12);
        bus.btn_left = 1'b0;
        wait_pulse(0, lat);
        chk("chord_pulse_seen", 32'({bus.left, bus.right}), 32'd3);
        #2;
        bus.btn_right = 1'b0;
        do_reset("rst_mid");
        run(10);
        clear_counts();
        bus.btn_left = 1'b1; run(10);
        bus.btn_left = 1'b0; run(12);
        chk("after_reset_click", 32'(cnt_l), 32'd1);
        chk("after_reset_right", 32'(cnt_r), 32'd0);

        // Randomised buttons, glitches and pointer strobes.
        for (int seg = 0; seg < 300; seg++) begin
            int dur;
            if ($urandom_range(0, 2) == 0) bus.btn_left  = ~bus.btn_left;
            if ($urandom_range(0, 2) == 0) bus.btn_right = ~bus.btn_right;
            if ($urandom_range(0, 3) == 0) bus.btn_retry = ~bus.btn_retry;
            dur = int'($urandom_range(1, 9));
            for (int c = 0; c < dur; c++) begin
                bus.xy_valid = ($urandom_range(0, 3) == 0);
                bus.mouse_x  = 10'($urandom_range(150, 480));
                bus.mouse_y  = 10'($urandom_range(80, 400));
                cycle();
            end
        end
        bus.xy_valid = 1'b0;
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_retry = 1'b0;
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ms_input.md
Name: ms_input

Overview:
- Upstream conditioner for the minesweeper core. Takes raw mouse button levels and pointer pixel coordinates.
- Produces the core's click controls:
  - single-cycle `left` / `right` pulses; a chord is signalled as both pulsing in the same cycle (core derives mid = left & right);
  - `cursor` tile index and `game_area` flag;
  - debounced `retry` pulse.
- Sits between the mouse/PS2 decoder and the minesweeper controller.

Parameters:
- BOARD_X0, 10'd192, pixel x of board left edge
- BOARD_Y0, 10'd112, pixel y of board top edge
- TILE_LOG2, 5, log2 of tile edge in pixels (tile = 32x32)
- DEB_CYCLES, 16'd50000, stable cycles required to accept a button level change

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- btn_left  in  1  raw left button level, 1 = pressed
- btn_right  in  1  raw right button level
- btn_retry  in  1  raw retry key level
- mouse_x  in  10  pointer x pixel
- mouse_y  in  10  pointer y pixel
- xy_valid  in  1  one-cycle strobe; mouse_x/mouse_y valid
- left  out  1  one-cycle left click pulse
- right  out  1  one-cycle right click pulse
- retry  out  1  one-cycle retry pulse
- cursor  out  6  tile index {row[2:0], col[2:0]}
- game_area  out  1  pointer inside the 8x8 board

Behaviour:
- Reset (async, active-high): every output is 0. Debounced levels are 0, counters are 0, FSM is IDLE.
- Debounce (per button: left, right, retry):
  - 2-flop synchroniser, then a counter.
  - Counter clears whenever the synchronised raw level equals the debounced level.
  - Otherwise it increments. On reaching DEB_CYCLES-1 the debounced level toggles and the counter clears.
  - Glitches shorter than DEB_CYCLES never toggle the level.
- Edge detect: press/release = debounced rise/fall, registered. Total latency raw → pulse is DEB_CYCLES+3 cycles.
- retry = debounced retry rising edge, 1 cycle.
- Coordinates, updated only on xy_valid:
  - dx = mouse_x - BOARD_X0 and dy = mouse_y - BOARD_Y0, computed 11-bit signed.
  - game_area <= (dx >= 0) && (dx >> TILE_LOG2) < 8 && (dy >= 0) && (dy >> TILE_LOG2) < 8.
  - cursor <= {dy[TILE_LOG2+2:TILE_LOG2], dx[TILE_LOG2+2:TILE_LOG2]}.
  - Both register one cycle after the strobe. Values hold between strobes.
  - Outside the board, cursor still updates (don't-care bits) and game_area = 0.
- Click FSM (states IDLE, L_HELD, R_HELD, CHORD, WAIT_REL):
  - IDLE: left press → L_HELD. Right press → R_HELD and right=1 (flag toggles on press). Both pressed in the same cycle → CHORD, no pulse.
  - L_HELD: left release → left=1, IDLE (reveal on release). Right press → CHORD.
  - R_HELD: right release → IDLE, no pulse. Left press → CHORD.
  - CHORD: release of either button → left=1 and right=1 in the same cycle, then WAIT_REL.
  - WAIT_REL: stay until both debounced levels are 0, then IDLE. Presses here emit nothing.
- Pulses are emitted regardless of game_area; the core gates on game_area.
- The cursor value presented with a pulse is the cursor register at that cycle. The FSM does not freeze the cursor.
- Simultaneous retry edge and click: both pulses are emitted independently.
- Reset mid-hold: FSM returns to IDLE. A button still held after reset is treated as a fresh press once the debounce re-qualifies it.

Decomposition:
- Shared package holds:
  - BOARD_DIM = 8 and CURSOR_W = 6;
  - the click FSM state encoding (3-bit).
- One natural sub-module: ms_debounce (sync + counter + level output, parameter DEB_CYCLES). Instantiated three times.

Test Plan:
- Bench runs with DEB_CYCLES=4.
- Reset released with btn_left=1 held → no pulse until 4+3 cycles later; left=1 for exactly 1 cycle only after the later release.
- btn_left bounce 1-0-1 over 3 cycles, then held 10 cycles and released → exactly one left pulse, on release, right=0 throughout.
- btn_right press held 20 cycles → right=1 one cycle at press. Release → no pulse.
- Chord: left press, right press 5 cycles later, right release → single cycle with left=1 and right=1. Subsequent left release → no pulse. FSM reaches IDLE.
- Coordinates:
  - mouse_x=192+3*32+5, mouse_y=112+6*32, xy_valid → next cycle cursor=6'b110_011, game_area=1.
  - mouse_x=191 → game_area=0.
  - mouse_y=112+256 → game_area=0.
- Async reset asserted mid-chord → outputs 0 immediately (no clock edge). After release, FSM is IDLE and a left click works normally.
